pacman_sprite_animator: RTL and testbench
=========================================

# pacman_sprite_animator

Animated Pac-Man sprite pixel source for the VGA path. Holds a parametrised multi-frame sprite ROM (shared closed frame plus half-open and open frames per direction), sequences the mouth animation from per-frame ticks, and answers per-pixel "is Pac-Man lit here" queries from the raster scanner with fixed 2-cycle latency. Sits between the game-state logic (position, direction, moving) and the colour mapper.

## Interface
Parameters:
- SPRITE_W, 16, sprite width in pixels (bits per ROM row)
- SPRITE_H, 16, sprite height in rows
- NUM_DIRS, 4, number of facing directions
- ANIM_DIV, 4, frame_ticks per mouth-phase step (≥1)
- COORD_W, 10, screen coordinate width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- dir  in  $clog2(NUM_DIRS)  facing: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
- moving  in  1  Pac-Man advanced this frame
- sprite_x, sprite_y  in  COORD_W  top-left of sprite box
- draw_x, draw_y  in  COORD_W  raster pixel being queried
- pix_valid  in  1  draw_x/draw_y valid this cycle
- pixel_on  out  1  sprite pixel lit
- pixel_valid  out  1  pix_valid delayed 2 cycles
- anim_frame  out  $clog2(1+2*NUM_DIRS)  frame index in use

## Operation
- ROM frame layout: frame 0 = closed (shared); frame 1+2d = half-open dir d; frame 2+2d = open dir d. Depth (1+2*NUM_DIRS)*SPRITE_H rows; row address = frame*SPRITE_H + row. Column 0 = row MSB.
- Mouth FSM states: CLOSED → HALF_OPEN → OPEN → HALF_CLOSE → CLOSED.
- Divider counter div_cnt (0..ANIM_DIV-1) increments on frame_tick only when moving=1; at ANIM_DIV-1 wraps to 0 and FSM advances one state. moving=0: counter and state hold.
- dir and FSM state are latched into anim_frame only on frame_tick (post-advance value), so the displayed frame never changes mid-field. CLOSED → 0; HALF_OPEN/HALF_CLOSE → 1+2*dir; OPEN → 2+2*dir.
- dir change and frame_tick in the same cycle: new dir takes effect in that latch.
- Hit test: dx = {0,draw_x} − {0,sprite_x}, dy likewise, in COORD_W+1 bits; hit = both non-negative and dx < SPRITE_W, dy < SPRITE_H. Sprite partly off the left/top edge: negative differences → hit=0, never wrap.
- pixel_on = hit & pix_valid-pipeline & rom_row[SPRITE_W-1-dx].

## Timing
- Reset: FSM CLOSED, div_cnt 0, anim_frame 0, pixel_on 0, pixel_valid 0, pipeline valid bits cleared.
- Cycle N: inputs sampled, hit/row/col computed, ROM address registered into sync ROM.
- Cycle N+1: ROM row available; hit, col, valid registered.
- Cycle N+2: pixel_on, pixel_valid registered outputs. Throughput one query per cycle, no stalls.
- anim_frame updates the cycle after frame_tick.
- pix_valid=0: pixel_valid=0 and pixel_on=0 two cycles later.
- reset asserted mid-stream: next cycle outputs 0, in-flight queries discarded, FSM to CLOSED.

## Structure
- pacman_pkg: dir_e enum (UP/DOWN/LEFT/RIGHT), mouth_e enum (CLOSED/HALF_OPEN/OPEN/HALF_CLOSE), default SPRITE_W/SPRITE_H constants, frame-index function.
- Sub-module pacman_sprite_rom: synchronous-read ROM, parameters SPRITE_W, SPRITE_H, NUM_DIRS; ports clk, addr, row. Initialised from bitmap literals; BRAM-inferable.
- Top holds FSM, divider, frame latch, hit logic, 2-stage pipeline.

## Test plan
- Reset, then 20 frame_ticks with moving=0 → anim_frame stays 0, div_cnt 0.
- moving=1, dir=3 (RIGHT), ANIM_DIV=4: anim_frame after ticks 4,8,12,16 → 7, 8, 7, 0.
- Sprite at (100,50), query (100+c,50+3) for c=0..15 on closed frame → pixel_on matches bits of row 3, MSB first, exactly 2 cycles later; query (99,53) and (116,53) → 0.
- Sprite at (0,0) with draw_x=0 and draw_x=1023 (dx would wrap) → 1023 gives pixel_on=0.
- dir change 3→0 asserted in the same cycle as the 4th tick → anim_frame becomes 1 (UP half-open), not 7.
- Back-to-back pix_valid stream, reset pulsed mid-stream → pixel_valid 0 the cycle after reset, anim_frame 0, resumes cleanly 2 cycles after reset drops.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite animator: facing directions,
// mouth phases, the default closed-sprite bitmap and the frame-index mapping.
package pacman_pkg;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_e;

  typedef enum logic [1:0] {CLOSED, HALF_OPEN, OPEN, HALF_CLOSE} mouth_e;

  localparam int DEF_SPRITE_W = 16;
  localparam int DEF_SPRITE_H = 16;

  // Closed (round) Pac-Man for the default 16x16 box; column 0 is the MSB.
  localparam logic [15:0] CLOSED_BITMAP [16] = '{
    16'h07E0, 16'h1FF8, 16'h3FFC, 16'h7FFE,
    16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE,
    16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h07E0
  };

  // Frame 0 is shared by all directions; each direction owns a half-open/open pair.
  function automatic int frame_index(input mouth_e m, input int d);
    case (m)
      CLOSED:  return 0;
      OPEN:    return 2 + 2 * d;
      default: return 1 + 2 * d;
    endcase
  endfunction

endpackage

// File: rtl/pacman_sprite_rom.sv
// Synchronous-read sprite ROM holding the closed frame followed by half-open/open
// frame pairs per direction; mouth wedges are cut from the closed bitmap at elaboration.
module pacman_sprite_rom
  import pacman_pkg::*;
#(
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H,
  parameter int NUM_DIRS = 4,
  localparam int DEPTH   = (1 + 2 * NUM_DIRS) * SPRITE_H,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  output logic [SPRITE_W-1:0] row
);

  function automatic logic [SPRITE_W-1:0] base_row(input int r);
    logic [SPRITE_W-1:0] w;
    int cx2, ry2;
    w = '0;
    if (SPRITE_W == 16 && SPRITE_H == 16) begin
      w = SPRITE_W'(CLOSED_BITMAP[r % 16]);
    end else begin
      for (int c = 0; c < SPRITE_W; c++) begin
        cx2 = 2 * c - (SPRITE_W - 1);
        ry2 = 2 * r - (SPRITE_H - 1);
        if (cx2 * cx2 * SPRITE_H * SPRITE_H + ry2 * ry2 * SPRITE_W * SPRITE_W
            <= SPRITE_W * SPRITE_W * SPRITE_H * SPRITE_H)
          w[SPRITE_W-1-c] = 1'b1;
      end
    end
    return w;
  endfunction

  // Coordinates are doubled so the sprite centre lands on integer (0,0).
  function automatic logic [SPRITE_W-1:0] rom_word(input int a);
    logic [SPRITE_W-1:0] w;
    int f, r, d, cx2, ry2, fx, fy, ay;
    bit open_mouth;
    f = a / SPRITE_H;
    r = a % SPRITE_H;
    w = base_row(r);
    if (f != 0) begin
      d          = ((f - 1) / 2) % 4;
      open_mouth = ((f - 1) % 2) == 1;
      for (int c = 0; c < SPRITE_W; c++) begin
        cx2 = 2 * c - (SPRITE_W - 1);
        ry2 = 2 * r - (SPRITE_H - 1);
        case (d)
          0:       begin fx = -ry2; fy = cx2; end
          1:       begin fx = ry2;  fy = cx2; end
          2:       begin fx = -cx2; fy = ry2; end
          default: begin fx = cx2;  fy = ry2; end
        endcase
        ay = (fy < 0) ? -fy : fy;
        if (fx > 0 && (open_mouth ? (ay <= fx) : (2 * ay <= fx)))
          w[SPRITE_W-1-c] = 1'b0;
      end
    end
    return w;
  endfunction

  logic [SPRITE_W-1:0] rom_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom_mem[gi] = rom_word(gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    row <= rom_mem[addr];
  end

endmodule

// File: rtl/pacman_sprite_animator.sv
// Animated Pac-Man pixel source: mouth-phase FSM paced by frame ticks, per-field frame
// latch, and a 2-cycle hit-test/ROM pipeline answering raster pixel queries.
module pacman_sprite_animator
  import pacman_pkg::*;
#(
  parameter int SPRITE_W  = DEF_SPRITE_W,
  parameter int SPRITE_H  = DEF_SPRITE_H,
  parameter int NUM_DIRS  = 4,
  parameter int ANIM_DIV  = 4,
  parameter int COORD_W   = 10,
  localparam int DIR_W    = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1,
  localparam int FRAME_W  = $clog2(1 + 2 * NUM_DIRS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [DIR_W-1:0]   dir,
  input  logic               moving,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               pix_valid,
  output logic               pixel_on,
  output logic               pixel_valid,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int ROM_AW = $clog2((1 + 2 * NUM_DIRS) * SPRITE_H);
  localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int COL_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  mouth_e             mouth_q, mouth_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FRAME_W-1:0] anim_frame_q, anim_frame_d;
  logic               step_en, phase_adv;

  always_comb begin
    step_en   = frame_tick & moving;
    phase_adv = step_en && (div_cnt_q == DIV_W'(ANIM_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mouth_q      <= CLOSED;
      div_cnt_q    <= '0;
      anim_frame_q <= '0;
    end else begin
      mouth_q      <= mouth_d;
      div_cnt_q    <= div_cnt_d;
      anim_frame_q <= anim_frame_d;
    end
  end

  always_comb begin
    mouth_d   = mouth_q;
    div_cnt_d = div_cnt_q;
    if (step_en) div_cnt_d = phase_adv ? '0 : div_cnt_q + 1'b1;
    if (phase_adv) begin
      case (mouth_q)
        CLOSED:    mouth_d = HALF_OPEN;
        HALF_OPEN: mouth_d = OPEN;
        OPEN:      mouth_d = HALF_CLOSE;
        default:   mouth_d = CLOSED;
      endcase
    end
  end

  // The latch uses the post-advance phase and the dir present on the tick itself.
  always_comb begin
    anim_frame_d = anim_frame_q;
    if (frame_tick) anim_frame_d = FRAME_W'(frame_index(mouth_d, int'(dir)));
  end

  assign anim_frame = anim_frame_q;

  logic [COORD_W:0]    dx, dy;
  logic                hit0;
  logic [ROM_AW-1:0]   rom_addr;
  logic [SPRITE_W-1:0] rom_row;

  // Zero-extended subtraction: a raster point left/above the box goes negative, not wraps.
  always_comb begin
    dx       = {1'b0, draw_x} - {1'b0, sprite_x};
    dy       = {1'b0, draw_y} - {1'b0, sprite_y};
    hit0     = !dx[COORD_W] && !dy[COORD_W]
               && (dx < (COORD_W + 1)'(SPRITE_W)) && (dy < (COORD_W + 1)'(SPRITE_H));
    rom_addr = ROM_AW'(int'(anim_frame_q) * SPRITE_H) + ROM_AW'(dy[ROW_W-1:0]);
  end

  pacman_sprite_rom #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .NUM_DIRS (NUM_DIRS)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .row  (rom_row)
  );

  logic             valid_q, hit_q, pixel_on_q, pixel_valid_q;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      hit_q         <= 1'b0;
      col_q         <= '0;
      pixel_on_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      valid_q       <= pix_valid;
      hit_q         <= hit0;
      col_q         <= dx[COL_W-1:0];
      pixel_valid_q <= valid_q;
      pixel_on_q    <= valid_q & hit_q & rom_row[COL_W'(SPRITE_W - 1) - col_q];
    end
  end

  assign pixel_on    = pixel_on_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_pacman_sprite_animator.sv
// Directed bench for pacman_sprite_animator: mouth sequencing, frame latching,
// hit-test boundaries and mid-stream reset, checked through a pixel scoreboard.
module tb_pacman_sprite_animator;
  import pacman_pkg::*;

  localparam int ANIM_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       moving = 1'b0;
  logic [9:0] sprite_x = '0, sprite_y = '0, draw_x = '0, draw_y = '0;
  logic       pix_valid = 1'b0;
  logic       pixel_on, pixel_valid;
  logic [3:0] anim_frame;

  pacman_sprite_animator #(
    .SPRITE_W (16), .SPRITE_H (16), .NUM_DIRS (4), .ANIM_DIV (ANIM_DIV), .COORD_W (10)
  ) dut (
    .clk (clk), .reset (reset), .frame_tick (frame_tick), .dir (dir), .moving (moving),
    .sprite_x (sprite_x), .sprite_y (sprite_y), .draw_x (draw_x), .draw_y (draw_y),
    .pix_valid (pix_valid), .pixel_on (pixel_on), .pixel_valid (pixel_valid),
    .anim_frame (anim_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        on;
    logic        valid;
    logic [15:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_div = 0;
  int   m_phase = 0;
  int   tick_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one query; compare the query issued two negedges earlier.
  task automatic query(input logic [9:0] x, input logic [9:0] y, input logic v,
                       input logic exp_on, input logic [15:0] id);
    exp_t e;
    @(negedge clk);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      $display("query id=%0d pixel_valid=%0d pixel_on=%0d", e.id, pixel_valid, pixel_on);
      check("pixel_valid", 32'(pixel_valid), 32'(e.valid));
      check("pixel_on", 32'(pixel_on), 32'(e.on));
    end
    draw_x = x; draw_y = y; pix_valid = v;
    e.on = exp_on & v; e.valid = v; e.id = id;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      pix_valid = 1'b0;
      e = sb.pop_front();
      $display("query id=%0d pixel_valid=%0d pixel_on=%0d", e.id, pixel_valid, pixel_on);
      check("pixel_valid", 32'(pixel_valid), 32'(e.valid));
      check("pixel_on", 32'(pixel_on), 32'(e.on));
    end
  endtask

  task automatic tick(input logic mv, input logic [1:0] d);
    int exp_frame;
    @(negedge clk);
    frame_tick = 1'b1; moving = mv; dir = d;
    if (mv) begin
      if (m_div == ANIM_DIV - 1) begin
        m_div = 0;
        m_phase = (m_phase + 1) % 4;
      end else begin
        m_div++;
      end
    end
    exp_frame = (m_phase == 0) ? 0 : (m_phase == 2) ? 2 + 2 * int'(d) : 1 + 2 * int'(d);
    @(negedge clk);
    frame_tick = 1'b0;
    tick_no++;
    $display("tick %0d moving=%0d dir=%0d anim_frame=%0d", tick_no, mv, d, anim_frame);
    check("anim_frame", 32'(anim_frame), 32'(exp_frame));
    check("div_cnt", 32'(dut.div_cnt_q), 32'(m_div));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] row3;
    logic [15:0] row0;
    int          spec_frames [4];
    row3 = 16'h7FFE;
    row0 = 16'h07E0;
    spec_frames = '{7, 8, 7, 0};

    // Reset state
    pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pixel_on", 32'(pixel_on), 32'd0);
    check("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    check("reset_anim_frame", 32'(anim_frame), 32'd0);
    check("reset_div_cnt", 32'(dut.div_cnt_q), 32'd0);
    pix_valid = 1'b0;
    reset = 1'b0;

    // Ticks while stationary: nothing advances
    for (int i = 0; i < 20; i++) tick(1'b0, 2'd3);

    // Moving right: full mouth cycle over 16 ticks
    tick_no = 0;
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, 2'd3);
      if (i % 4 == 0) check("spec_frame_seq", 32'(anim_frame), 32'(spec_frames[i/4 - 1]));
    end

    // Closed frame row 3, sprite at (100,50)
    sprite_x = 10'd100; sprite_y = 10'd50;
    for (int c = 0; c < 16; c++)
      query(10'(100 + c), 10'd53, 1'b1, row3[15 - c], 16'(c));
    query(10'd99, 10'd53, 1'b1, 1'b0, 16'd16);
    query(10'd116, 10'd53, 1'b1, 1'b0, 16'd17);
    query(10'd105, 10'd53, 1'b0, 1'b0, 16'd18);
    drain();

    // Top-left corner: wrapped differences must miss
    sprite_x = 10'd0; sprite_y = 10'd0;
    query(10'd5, 10'd0, 1'b1, row0[10], 16'd20);
    query(10'd0, 10'd0, 1'b1, row0[15], 16'd21);
    query(10'd1023, 10'd0, 1'b1, 1'b0, 16'd22);
    query(10'd3, 10'd1023, 1'b1, 1'b0, 16'd23);
    drain();

    // Direction change on the phase-advancing tick takes effect immediately
    for (int i = 0; i < 3; i++) tick(1'b1, 2'd3);
    tick(1'b1, 2'd0);
    check("dir_change_frame", 32'(anim_frame), 32'd1);

    // dir change without a tick leaves the displayed frame alone
    @(negedge clk);
    dir = 2'd2;
    repeat (2) @(negedge clk);
    check("frame_hold_no_tick", 32'(anim_frame), 32'd1);

    // Streaming queries on row 8 (solid in closed and UP half-open), reset mid-stream
    sprite_x = 10'd100; sprite_y = 10'd50;
    for (int i = 0; i < 6; i++) query(10'(100 + 2 * i), 10'd58, 1'b1, 1'b1, 16'(30 + i));
    query(10'd116, 10'd58, 1'b1, 1'b0, 16'd36);
    @(negedge clk);
    reset = 1'b1;
    draw_x = 10'd101; draw_y = 10'd58; pix_valid = 1'b1;
    sb.delete();
    @(negedge clk);
    $display("reset pulse pixel_valid=%0d pixel_on=%0d anim_frame=%0d", pixel_valid, pixel_on, anim_frame);
    check("midreset_pixel_valid", 32'(pixel_valid), 32'd0);
    check("midreset_pixel_on", 32'(pixel_on), 32'd0);
    check("midreset_anim_frame", 32'(anim_frame), 32'd0);
    reset = 1'b0;
    pix_valid = 1'b0;
    m_div = 0; m_phase = 0;
    for (int i = 0; i < 6; i++) query(10'(103 + 2 * i), 10'd58, 1'b1, 1'b1, 16'(40 + i));
    query(10'd99, 10'd58, 1'b1, 1'b0, 16'd46);
    query(10'd108, 10'd66, 1'b1, 1'b0, 16'd47);
    drain();
    tick(1'b1, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
